// File: rtl/reset_sequencer.sv
// Board reset generator: qualifies PLL lock, holds, then releases stages in order.
// Registered outputs; lock input sees 2-edge sync latency; no flow control.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  sw_reset,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  ready,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || LOCK_CYCLES < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
      longint'(LOCK_CYCLES) >= (longint'(1) << CNT_WIDTH) ||
      longint'(HOLD_CYCLES) >= (longint'(1) << CNT_WIDTH) ||
      longint'(STAGE_GAP)   >= (longint'(1) << CNT_WIDTH)) begin : g_bad_params
    $error("reset_sequencer: cycle parameter out of range for CNT_WIDTH");
  end

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  stage_q, stage_d;
  logic                   ready_q, ready_d;
  logic                   lock_meta, locked_s;
  logic                   abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      stage_q   <= '1;
      ready_q   <= 1'b0;
    end else begin
      lock_meta <= locked;
      locked_s  <= lock_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      ready_q   <= ready_d;
    end
  end

  // Lock loss outranks a software request; both only matter once lock is qualified.
  assign abort = (state_q != WAIT_LOCK) && (!locked_s || sw_reset);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (locked_s && cnt_q == LOCK_LAST) state_d = HOLD;
      HOLD: begin
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (sw_reset)           state_d = HOLD;
        else if (cnt_q == HOLD_LAST) state_d = (NUM_STAGES == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if (!locked_s)                                   state_d = WAIT_LOCK;
        else if (sw_reset)                               state_d = HOLD;
        else if (cnt_q == GAP_LAST && idx_q == LAST_IDX) state_d = RUN;
      end
      RUN: begin
        if (!locked_s)     state_d = WAIT_LOCK;
        else if (sw_reset) state_d = HOLD;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    if (abort) begin
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          stage_d = '1;
          if (!locked_s || cnt_q == LOCK_LAST) cnt_d = '0;
          else                                 cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            stage_d[0] = 1'b0;
            idx_d      = IDX_W'(1);
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int k = 0; k < NUM_STAGES; k++)
              if (k == int'(idx_q)) stage_d[k] = 1'b0;
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
    ready_d = (state_d == RUN);
  end

  assign stage_reset = stage_q;
  assign ready       = ready_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal 1-stage instance on shared inputs.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset, locked, sw_reset;
  logic [2:0] stage_reset;
  logic       ready;
  logic [1:0] state;
  logic [0:0] s_stage_reset;
  logic       s_ready;
  logic [1:0] s_state;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk(clk), .reset(reset), .locked(locked), .sw_reset(sw_reset),
    .stage_reset(stage_reset), .ready(ready), .state(state)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .LOCK_CYCLES(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .CNT_WIDTH(8)
  ) dut_s (
    .clk(clk), .reset(reset), .locked(locked), .sw_reset(sw_reset),
    .stage_reset(s_stage_reset), .ready(s_ready), .state(s_state)
  );

  // Reference: 't' is edges elapsed since lock qualification (or last sw restart);
  // every output follows arithmetically from it.
  typedef struct { bit m1; bit m2; bit qual; int run; int t; } mdl_t;
  mdl_t md, ms;

  function automatic mdl_t mstep(mdl_t m, bit lk, bit sw, int lc, int hc, int gc, int n);
    mdl_t r  = m;
    bit   ls = m.m2;
    r.m2 = m.m1;
    r.m1 = lk;
    if (!m.qual) begin
      r.run = ls ? m.run + 1 : 0;
      if (r.run == lc) begin r.qual = 1; r.run = 0; r.t = 0; end
    end else if (!ls) begin
      r.qual = 0; r.run = 0; r.t = 0;
    end else if (sw) begin
      r.t = 0;
    end else if (m.t < hc + (n - 1) * gc) begin
      r.t = m.t + 1;
    end
    return r;
  endfunction

  function automatic logic [1:0] mstate(mdl_t m, int hc, int gc, int n);
    if (!m.qual)                    return 2'd0;
    if (m.t < hc)                   return 2'd1;
    if (m.t >= hc + (n - 1) * gc)   return 2'd3;
    return 2'd2;
  endfunction

  function automatic logic [2:0] mstage(mdl_t m, int hc, int gc, int n);
    logic [2:0] v = 3'b111;
    for (int k = 0; k < n; k++)
      if (m.qual && m.t >= hc + k * gc) v[k] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [2:0] es;
    @(posedge clk);
    if (reset) begin
      md = mstep(md, locked, sw_reset, 16, 10, 4, 3);
      ms = mstep(ms, locked, sw_reset, 1, 1, 4, 1);
    end
    @(negedge clk);
    chk("model_state", 32'(state), 32'(mstate(md, 10, 4, 3)));
    chk("model_stage", 32'(stage_reset), 32'(mstage(md, 10, 4, 3)));
    chk("model_ready", 32'(ready), 32'(mstate(md, 10, 4, 3) == 2'd3));
    es = mstage(ms, 1, 4, 1);
    chk("model_s_state", 32'(s_state), 32'(mstate(ms, 1, 4, 1)));
    chk("model_s_stage", 32'(s_stage_reset), 32'(es[0]));
    chk("model_s_ready", 32'(s_ready), 32'(mstate(ms, 1, 4, 1) == 2'd3));
  endtask

  task automatic do_reset();
    reset = 1'b0; locked = 1'b0; sw_reset = 1'b0;
    md = '{default: 0};
    ms = '{default: 0};
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stage", 32'(stage_reset), 32'h7);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_s_stage", 32'(s_stage_reset), 32'h1);
    reset = 1'b1;
  endtask

  typedef struct { int n; bit lk; bit sw; logic [1:0] st; logic [2:0] sr; logic rdy; } vec_t;
  vec_t tbl[9];

  initial begin
    int drop = 0;
    // Power-on then lock loss in RUN; each row runs n edges with the given inputs.
    tbl[0] = '{17, 1'b1, 1'b0, 2'd0, 3'b111, 1'b0};
    tbl[1] = '{ 1, 1'b1, 1'b0, 2'd1, 3'b111, 1'b0};
    tbl[2] = '{ 9, 1'b1, 1'b0, 2'd1, 3'b111, 1'b0};
    tbl[3] = '{ 1, 1'b1, 1'b0, 2'd2, 3'b110, 1'b0};
    tbl[4] = '{ 3, 1'b1, 1'b0, 2'd2, 3'b110, 1'b0};
    tbl[5] = '{ 1, 1'b1, 1'b0, 2'd2, 3'b100, 1'b0};
    tbl[6] = '{ 4, 1'b1, 1'b0, 2'd3, 3'b000, 1'b1};
    tbl[7] = '{ 2, 1'b0, 1'b0, 2'd3, 3'b000, 1'b1};
    tbl[8] = '{ 1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      locked = tbl[i].lk; sw_reset = tbl[i].sw;
      repeat (tbl[i].n) tick();
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_stage", i), 32'(stage_reset), 32'(tbl[i].sr));
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
    end

    // Minimal instance: HOLD at edge 3, released and ready at edge 4.
    do_reset();
    locked = 1'b1;
    repeat (2) tick();
    chk("min_e2_state", 32'(s_state), 32'd0);
    tick();
    chk("min_e3_state", 32'(s_state), 32'd1);
    chk("min_e3_stage", 32'(s_stage_reset), 32'd1);
    tick();
    chk("min_e4_state", 32'(s_state), 32'd3);
    chk("min_e4_stage", 32'(s_stage_reset), 32'd0);
    chk("min_e4_ready", 32'(s_ready), 32'd1);

    // One-cycle lock glitch after 10 qualified edges restarts qualification.
    do_reset();
    locked = 1'b1;
    repeat (12) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    repeat (5) tick();
    chk("glitch_e18_state", 32'(state), 32'd0);
    repeat (12) tick();
    chk("glitch_e30_state", 32'(state), 32'd0);
    tick();
    chk("glitch_e31_state", 32'(state), 32'd1);

    // sw_reset in RELEASE, then sw_reset coinciding with lock loss.
    do_reset();
    locked = 1'b1;
    repeat (29) tick();
    chk("sw_pre_stage", 32'(stage_reset), 32'h6);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    chk("sw_stage", 32'(stage_reset), 32'h7);
    chk("sw_state", 32'(state), 32'd1);
    repeat (9) tick();
    chk("sw_e39_stage", 32'(stage_reset), 32'h7);
    tick();
    chk("sw_e40_stage", 32'(stage_reset), 32'h6);
    chk("sw_e40_state", 32'(state), 32'd2);
    repeat (12) tick();
    chk("sw_run_state", 32'(state), 32'd3);
    locked = 1'b0;
    repeat (2) tick();
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    chk("both_state", 32'(state), 32'd0);
    chk("both_stage", 32'(stage_reset), 32'h7);

    // Async reset between edges mid-RELEASE.
    do_reset();
    locked = 1'b1;
    repeat (33) tick();
    chk("async_pre_stage", 32'(stage_reset), 32'h4);
    #2 reset = 1'b0;
    md = '{default: 0};
    ms = '{default: 0};
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_stage", 32'(stage_reset), 32'h7);
    chk("async_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Random lock drops and sw requests against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (drop > 0) begin
        locked = 1'b0;
        drop--;
      end else begin
        locked = 1'b1;
        if ($urandom_range(0, 149) == 0) drop = $urandom_range(1, 6);
      end
      sw_reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
